trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer for the NPC core. It is the initiator side of the CSR register-file access port. On `ecall`, `ebreak` or `mret` from the execute stage, it runs a fixed sequence of CSR reads and writes: saving `mepc` and `mcause`, updating `mstatus`, and fetching `mtvec` or `mepc`. It then issues a one-cycle PC redirect to the fetch stage. It sits between the decode/execute control and the CSR file.

## Interface
- `CAUSE_ECALL`, default 11: `mcause` value written for `ecall` (M-mode).
- `CAUSE_EBREAK`, default 3: `mcause` value written for `ebreak`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `trap_valid` in 1: trap request from execute.
- `trap_ready` out 1: high only in IDLE; a request is accepted when `trap_valid` and `trap_ready` are both high at a clock edge.
- `trap_type` in 2: request type. 00 = ecall, 01 = ebreak, 10 = mret, 11 = reserved.
- `trap_pc` in 32: PC of the trapping instruction.
- `csr_req` out 1: CSR access request.
- `csr_we` out 1: 1 = write, 0 = read.
- `csr_addr` out 12: CSR address.
- `csr_wdata` out 32: write data.
- `csr_rdata` in 32: read data, valid in the cycle `csr_ack` is high.
- `csr_ack` in 1: access complete. May be tied high for a combinational CSR file.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 32: new fetch PC, valid with `redirect_valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
- CSR addresses: `mstatus` 0x300, `mtvec` 0x305, `mepc` 0x341, `mcause` 0x342.
- On accept, the block latches `trap_pc` into `pc_q` and `trap_type` into `type_q`.
- ecall/ebreak sequence: W_MEPC (write `pc_q`) → W_MCAUSE (write the cause parameter, zero-extended) → R_MSTATUS → W_MSTATUS → R_MTVEC → REDIRECT → IDLE.
- mret sequence: R_MEPC → R_MSTATUS → W_MSTATUS → REDIRECT → IDLE.
- Read data:
  - Values read in R_* states are captured into `rd_q` on `csr_ack`.
  - For `mstatus`, the captured value goes into `ms_q`.
- Trap-entry `mstatus` write: `ms_q` with MPIE[7] ← MIE[3], MIE[3] ← 0, MPP[12:11] ← 2'b11. All other bits are unchanged.
- mret `mstatus` write: `ms_q` with MIE[3] ← MPIE[7], MPIE[7] ← 1, MPP ← 2'b11 (M-only core). All other bits are unchanged.
- Redirect target:
  - ecall/ebreak: `mtvec & 32'hFFFF_FFFC` (direct mode only; the mode bits are ignored).
  - mret: `mepc & 32'hFFFF_FFFC`.
- Reserved `trap_type` 11 is accepted and dropped. The FSM stays in IDLE, generates no CSR traffic and no redirect.
- Each access state drives `csr_req=1` with `csr_we`, `csr_addr` and `csr_wdata` held stable. The FSM advances only on an edge where `csr_ack=1`.
- In IDLE and REDIRECT, `csr_req=0` and `csr_wdata=0`.

## Timing
- Reset values: `csr_req` 0, `csr_we` 0, `csr_addr` 0, `csr_wdata` 0, `redirect_valid` 0, `redirect_pc` 0, `busy` 0, `trap_ready` 1. State is IDLE; `pc_q`, `rd_q` and `ms_q` are 0.
- All outputs are registered or decoded from the state register. None depends combinationally on `trap_valid` or `csr_ack`.
- Latency with `csr_ack` tied high, request accepted at edge 0:
  - ecall/ebreak: access states occupy cycles 1–5; `redirect_valid` is high in cycle 6; `trap_ready` is high again in cycle 7.
  - mret: `redirect_valid` is high in cycle 4.
- Each cycle of `csr_ack=0` stretches the current state by one cycle. There is no timeout.
- `redirect_valid` is high for exactly one cycle per accepted non-reserved request.
- `rst` asserted in any state:
  - At the next edge the FSM is in IDLE and all outputs take their reset values.
  - The in-flight sequence is abandoned; no redirect is issued and partial CSR writes are not undone.
  - `rst` has priority over `csr_ack` and `trap_valid` in the same cycle.
- `trap_valid` while `busy`: not accepted. The requester holds the request.

## Configuration
- `TRAP_MSTATUS_EN` defined: R_MSTATUS and W_MSTATUS are included as described.
- `TRAP_MSTATUS_EN` undefined:
  - Both `mstatus` states are skipped and `mstatus` is never accessed.
  - ecall latency becomes 4 (redirect in cycle 4); mret latency becomes 2.

## Test plan
- ecall, `trap_pc`=0x8000_0010, ack tied high, `mstatus`=0x0000_0008, `mtvec`=0x8000_0100 → write 0x341=0x8000_0010, write 0x342=11, write 0x300=0x0000_1880, redirect 0x8000_0100 in cycle 6.
- mret with `mepc`=0x8000_0014, `mstatus`=0x0000_1880 → write 0x300=0x0000_1888, redirect 0x8000_0014 in cycle 4.
- ebreak with `csr_ack` low for 2 cycles in W_MCAUSE → `csr_addr` 0x342 and `csr_wdata` 3 held stable for 3 cycles; redirect in cycle 8.
- `mtvec`=0x8000_0103 → redirect 0x8000_0100.
- `rst` in W_MCAUSE → next cycle IDLE, `csr_req`=0, `trap_ready`=1, no `redirect_valid` pulse ever; `trap_type`=11 → no CSR traffic.
- Build without `TRAP_MSTATUS_EN` → no access to 0x300; ecall redirect in cycle 4.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Trap request, CSR access and redirect signals for trap_ctrl.
// master = the trap sequencer itself; slave = execute stage, CSR file and fetch.
interface trap_ctrl_if;
  logic        trap_valid;
  logic        trap_ready;
  logic [1:0]  trap_type;
  logic [31:0] trap_pc;
  logic        csr_req;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    input  trap_valid, trap_type, trap_pc, csr_rdata, csr_ack,
    output trap_ready, csr_req, csr_we, csr_addr, csr_wdata,
    output redirect_valid, redirect_pc, busy
  );

  modport slave (
    output trap_valid, trap_type, trap_pc, csr_rdata, csr_ack,
    input  trap_ready, csr_req, csr_we, csr_addr, csr_wdata,
    input  redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode trap sequencer: CSR save/restore then a one-cycle redirect; each access waits on csr_ack.
// Redirect at cycle 6/4 (ecall/mret) with TRAP_MSTATUS_EN, 4/2 without; requests only taken in IDLE.
module trap_ctrl #(
  parameter int unsigned CAUSE_ECALL  = 11,
  parameter int unsigned CAUSE_EBREAK = 3
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.master bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_MEPC    = 3'd1;
  localparam logic [2:0] W_MCAUSE  = 3'd2;
`ifdef TRAP_MSTATUS_EN
  localparam logic [2:0] R_MSTATUS = 3'd3;
  localparam logic [2:0] W_MSTATUS = 3'd4;
`endif
  localparam logic [2:0] R_MTVEC   = 3'd5;
  localparam logic [2:0] R_MEPC    = 3'd6;
  localparam logic [2:0] REDIRECT  = 3'd7;

  localparam logic [1:0] T_ECALL  = 2'b00;
  localparam logic [1:0] T_EBREAK = 2'b01;
  localparam logic [1:0] T_MRET   = 2'b10;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [2:0]  state, state_nxt;
  logic [1:0]  type_q;
  logic [31:0] pc_q;
  logic [31:0] rd_q;
  logic        accept;
  logic        is_mret;
  logic [31:0] cause_val;

  assign accept    = bus.trap_valid && (state == IDLE);
  assign is_mret   = (type_q == T_MRET);
  assign cause_val = (type_q == T_EBREAK) ? 32'(CAUSE_EBREAK) : 32'(CAUSE_ECALL);

`ifdef TRAP_MSTATUS_EN
  logic [31:0] ms_q;
  logic [31:0] ms_wdata;

  // Entry stacks MIE into MPIE; mret pops it back. MPP is always M on this core.
  always_comb begin
    ms_wdata = ms_q;
    if (is_mret) begin
      ms_wdata[3] = ms_q[7];
      ms_wdata[7] = 1'b1;
    end else begin
      ms_wdata[7] = ms_q[3];
      ms_wdata[3] = 1'b0;
    end
    ms_wdata[12:11] = 2'b11;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.trap_valid) begin
          case (bus.trap_type)
            T_ECALL, T_EBREAK: state_nxt = W_MEPC;
            T_MRET:            state_nxt = R_MEPC;
            default:           state_nxt = IDLE;
          endcase
        end
      end
      W_MEPC:   if (bus.csr_ack) state_nxt = W_MCAUSE;
`ifdef TRAP_MSTATUS_EN
      W_MCAUSE:  if (bus.csr_ack) state_nxt = R_MSTATUS;
      R_MSTATUS: if (bus.csr_ack) state_nxt = W_MSTATUS;
      W_MSTATUS: if (bus.csr_ack) state_nxt = is_mret ? REDIRECT : R_MTVEC;
      R_MEPC:    if (bus.csr_ack) state_nxt = R_MSTATUS;
`else
      W_MCAUSE:  if (bus.csr_ack) state_nxt = R_MTVEC;
      R_MEPC:    if (bus.csr_ack) state_nxt = REDIRECT;
`endif
      R_MTVEC:  if (bus.csr_ack) state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      type_q <= 2'b00;
      pc_q   <= 32'h0;
      rd_q   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        type_q <= bus.trap_type;
        pc_q   <= bus.trap_pc;
      end
      if (bus.csr_ack && (state == R_MTVEC || state == R_MEPC))
        rd_q <= bus.csr_rdata;
    end
  end

`ifdef TRAP_MSTATUS_EN
  always_ff @(posedge clk) begin
    if (rst)
      ms_q <= 32'h0;
    else if (bus.csr_ack && state == R_MSTATUS)
      ms_q <= bus.csr_rdata;
  end
`endif

  // Everything below decodes from registered state, so no input reaches an output combinationally.
  always_comb begin
    bus.csr_req   = 1'b0;
    bus.csr_we    = 1'b0;
    bus.csr_addr  = 12'h0;
    bus.csr_wdata = 32'h0;
    case (state)
      W_MEPC: begin
        bus.csr_req   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = A_MEPC;
        bus.csr_wdata = pc_q;
      end
      W_MCAUSE: begin
        bus.csr_req   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = A_MCAUSE;
        bus.csr_wdata = cause_val;
      end
`ifdef TRAP_MSTATUS_EN
      R_MSTATUS: begin
        bus.csr_req  = 1'b1;
        bus.csr_addr = A_MSTATUS;
      end
      W_MSTATUS: begin
        bus.csr_req   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = A_MSTATUS;
        bus.csr_wdata = ms_wdata;
      end
`endif
      R_MTVEC: begin
        bus.csr_req  = 1'b1;
        bus.csr_addr = A_MTVEC;
      end
      R_MEPC: begin
        bus.csr_req  = 1'b1;
        bus.csr_addr = A_MEPC;
      end
      default: begin
        bus.csr_req   = 1'b0;
        bus.csr_we    = 1'b0;
        bus.csr_addr  = 12'h0;
        bus.csr_wdata = 32'h0;
      end
    endcase
  end

  // Only direct-mode mtvec is supported, so the low two bits are dropped for both targets.
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.redirect_pc    = (state == REDIRECT) ? (rd_q & 32'hFFFF_FFFC) : 32'h0;
  assign bus.busy           = (state != IDLE);
  assign bus.trap_ready     = (state == IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; expectations follow TRAP_MSTATUS_EN when it is defined.
module tb_trap_ctrl;
`ifdef TRAP_MSTATUS_EN
  localparam bit MS_EN = 1'b1;
`else
  localparam bit MS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if bus();
  trap_ctrl #(.CAUSE_ECALL(11), .CAUSE_EBREAK(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passes = 0;

  // CSR file model: reads return preset values, writes are logged.
  logic [31:0] pre_ms = 32'h0, pre_tvec = 32'h0, pre_epc = 32'h0;
  logic [31:0] w_mepc = 32'h0, w_mcause = 32'h0, w_ms = 32'h0;
  int n_acc = 0;
  int n300 = 0;

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = pre_ms;
      12'h305: bus.csr_rdata = pre_tvec;
      12'h341: bus.csr_rdata = pre_epc;
      default: bus.csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!rst && bus.csr_req && bus.csr_ack) begin
      n_acc <= n_acc + 1;
      if (bus.csr_addr == 12'h300) n300 <= n300 + 1;
      if (bus.csr_we) begin
        case (bus.csr_addr)
          12'h341: w_mepc   <= bus.csr_wdata;
          12'h342: w_mcause <= bus.csr_wdata;
          12'h300: w_ms     <= bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

  // Issues one request; cycle numbers count from the accepting edge (edge 0).
  task automatic run_trap(input logic [1:0] t, input logic [31:0] pc, input int stall,
                          output int rcyc, output logic [31:0] rpc, output int pulses,
                          output int endc, output int hold);
    int st;
    st = stall;
    rcyc = -1; rpc = 32'h0; pulses = 0; endc = -1; hold = 0;
    @(negedge clk);
    bus.trap_valid = 1'b1; bus.trap_type = t; bus.trap_pc = pc;
    @(negedge clk);
    bus.trap_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (st > 0 && bus.csr_req && bus.csr_addr == 12'h342) begin
        bus.csr_ack = 1'b0;
        st--;
      end else begin
        bus.csr_ack = 1'b1;
      end
      if (bus.csr_req && bus.csr_addr == 12'h342 && bus.csr_wdata == 32'd3) hold++;
      if (bus.redirect_valid) begin
        pulses++;
        if (rcyc < 0) begin rcyc = c; rpc = bus.redirect_pc; end
      end
      if (bus.trap_ready) begin endc = c; break; end
      @(negedge clk);
    end
    bus.csr_ack = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus.csr_req !== 1'b0) $display("FAIL rst_csr_req got %b want 0", bus.csr_req); else passes++;
    checks++; if (bus.csr_we !== 1'b0) $display("FAIL rst_csr_we got %b want 0", bus.csr_we); else passes++;
    checks++; if (bus.csr_addr !== 12'h0) $display("FAIL rst_csr_addr got %h want 0", bus.csr_addr); else passes++;
    checks++; if (bus.csr_wdata !== 32'h0) $display("FAIL rst_csr_wdata got %h want 0", bus.csr_wdata); else passes++;
    checks++; if (bus.redirect_valid !== 1'b0) $display("FAIL rst_redir_vld got %b want 0", bus.redirect_valid); else passes++;
    checks++; if (bus.redirect_pc !== 32'h0) $display("FAIL rst_redir_pc got %h want 0", bus.redirect_pc); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else passes++;
    checks++; if (bus.trap_ready !== 1'b1) $display("FAIL rst_trap_ready got %b want 1", bus.trap_ready); else passes++;
  endtask

  task automatic test_ecall;
    int rc, pl, ec, hd, a0, s0;
    logic [31:0] rp, ms0, ms_exp;
    pre_ms = 32'h0000_0008; pre_tvec = 32'h8000_0100;
    a0 = n_acc; s0 = n300; ms0 = w_ms;
    ms_exp = MS_EN ? 32'h0000_1880 : ms0;
    run_trap(2'b00, 32'h8000_0010, 0, rc, rp, pl, ec, hd);
    checks++; if (rc !== (MS_EN ? 6 : 4)) $display("FAIL ecall_redir_cycle got %0d want %0d", rc, MS_EN ? 6 : 4); else passes++;
    checks++; if (rp !== 32'h8000_0100) $display("FAIL ecall_redir_pc got %h want 80000100", rp); else passes++;
    checks++; if (pl !== 1) $display("FAIL ecall_pulses got %0d want 1", pl); else passes++;
    checks++; if (ec !== (MS_EN ? 7 : 5)) $display("FAIL ecall_ready_cycle got %0d want %0d", ec, MS_EN ? 7 : 5); else passes++;
    checks++; if (w_mepc !== 32'h8000_0010) $display("FAIL ecall_mepc got %h want 80000010", w_mepc); else passes++;
    checks++; if (w_mcause !== 32'd11) $display("FAIL ecall_mcause got %h want b", w_mcause); else passes++;
    checks++; if (w_ms !== ms_exp) $display("FAIL ecall_mstatus got %h want %h", w_ms, ms_exp); else passes++;
    checks++; if (n300 - s0 !== (MS_EN ? 2 : 0)) $display("FAIL ecall_mstatus_acc got %0d want %0d", n300 - s0, MS_EN ? 2 : 0); else passes++;
    checks++; if (n_acc - a0 !== (MS_EN ? 5 : 3)) $display("FAIL ecall_acc got %0d want %0d", n_acc - a0, MS_EN ? 5 : 3); else passes++;
  endtask

  task automatic test_mret;
    int rc, pl, ec, hd, a0;
    logic [31:0] rp, ms0, ms_exp;
    pre_ms = 32'h0000_1880; pre_epc = 32'h8000_0014;
    a0 = n_acc; ms0 = w_ms;
    ms_exp = MS_EN ? 32'h0000_1888 : ms0;
    run_trap(2'b10, 32'h1234_5678, 0, rc, rp, pl, ec, hd);
    checks++; if (rc !== (MS_EN ? 4 : 2)) $display("FAIL mret_redir_cycle got %0d want %0d", rc, MS_EN ? 4 : 2); else passes++;
    checks++; if (rp !== 32'h8000_0014) $display("FAIL mret_redir_pc got %h want 80000014", rp); else passes++;
    checks++; if (w_ms !== ms_exp) $display("FAIL mret_mstatus got %h want %h", w_ms, ms_exp); else passes++;
    checks++; if (n_acc - a0 !== (MS_EN ? 3 : 1)) $display("FAIL mret_acc got %0d want %0d", n_acc - a0, MS_EN ? 3 : 1); else passes++;
  endtask

  task automatic test_mtvec_mask;
    int rc, pl, ec, hd;
    logic [31:0] rp;
    pre_ms = 32'h0; pre_tvec = 32'h8000_0103;
    run_trap(2'b00, 32'h8000_0040, 0, rc, rp, pl, ec, hd);
    checks++; if (rp !== 32'h8000_0100) $display("FAIL mask_redir_pc got %h want 80000100", rp); else passes++;
    checks++; if (pl !== 1) $display("FAIL mask_pulses got %0d want 1", pl); else passes++;
  endtask

  task automatic test_ebreak_stall;
    int rc, pl, ec, hd;
    logic [31:0] rp;
    pre_tvec = 32'h8000_0200;
    run_trap(2'b01, 32'h8000_0020, 2, rc, rp, pl, ec, hd);
    checks++; if (hd !== 3) $display("FAIL stall_hold got %0d want 3", hd); else passes++;
    checks++; if (rc !== (MS_EN ? 8 : 6)) $display("FAIL stall_redir_cycle got %0d want %0d", rc, MS_EN ? 8 : 6); else passes++;
    checks++; if (w_mcause !== 32'd3) $display("FAIL stall_mcause got %h want 3", w_mcause); else passes++;
    checks++; if (rp !== 32'h8000_0200) $display("FAIL stall_redir_pc got %h want 80000200", rp); else passes++;
  endtask

  task automatic test_reset_mid;
    int pl;
    pl = 0;
    @(negedge clk);
    bus.trap_valid = 1'b1; bus.trap_type = 2'b00; bus.trap_pc = 32'h8000_0080;
    @(negedge clk);
    bus.trap_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.csr_addr !== 12'h342) $display("FAIL rmid_in_mcause got %h want 342", bus.csr_addr); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.csr_req !== 1'b0) $display("FAIL rmid_csr_req got %b want 0", bus.csr_req); else passes++;
    checks++; if (bus.trap_ready !== 1'b1) $display("FAIL rmid_trap_ready got %b want 1", bus.trap_ready); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", bus.busy); else passes++;
    for (int c = 0; c < 12; c++) begin
      if (bus.redirect_valid) pl++;
      @(negedge clk);
    end
    checks++; if (pl !== 0) $display("FAIL rmid_redirect got %0d pulses want 0", pl); else passes++;
  endtask

  task automatic test_reserved;
    int rc, pl, ec, hd, a0;
    logic [31:0] rp;
    a0 = n_acc;
    run_trap(2'b11, 32'h8000_00C0, 0, rc, rp, pl, ec, hd);
    repeat (8) begin
      if (bus.redirect_valid) pl++;
      @(negedge clk);
    end
    checks++; if (n_acc - a0 !== 0) $display("FAIL rsvd_acc got %0d want 0", n_acc - a0); else passes++;
    checks++; if (pl !== 0) $display("FAIL rsvd_pulses got %0d want 0", pl); else passes++;
    checks++; if (ec !== 1) $display("FAIL rsvd_ready_cycle got %0d want 1", ec); else passes++;
  endtask

  initial begin
    bus.trap_valid = 1'b0;
    bus.trap_type  = 2'b00;
    bus.trap_pc    = 32'h0;
    bus.csr_ack    = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_ecall;
    test_mret;
    test_mtvec_mask;
    test_ebreak_stall;
    test_reset_mid;
    test_reserved;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
